// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word load, one bit per clock,
// registered frame markers and optional trailing even-parity bit.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int unsigned FRAME_LEN = WIDTH + (PARITY_EN ? 1 : 0);
  localparam int unsigned CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAR} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_inc;
  logic             r_par;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_frame_start;
  logic             r_frame_end;
  logic             w_last;
  logic             w_accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = ST_SHIFT;
      ST_SHIFT: begin
        if (r_cnt == LAST_DATA) begin
          if (PARITY_EN)     w_next_state = ST_PAR;
          else if (w_accept) w_next_state = ST_SHIFT;
          else               w_next_state = ST_IDLE;
        end
      end
      ST_PAR:   w_next_state = w_accept ? ST_SHIFT : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // The last frame bit is on the wire while r_cnt == LAST_IDX, so a new
  // word can be taken on that edge for a zero-gap back-to-back frame.
  always_comb begin
    w_last     = (r_state != ST_IDLE) && (r_cnt == LAST_IDX);
    load_ready = (r_state == ST_IDLE) || w_last;
    w_accept   = load_valid && load_ready;
    busy       = (r_state != ST_IDLE);
    w_cnt_inc  = r_cnt + 1'b1;
  end

  // r_shift holds the not-yet-sent bits, already advanced past the bit on ser_out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift       <= '0;
      r_cnt         <= '0;
      r_par         <= 1'b0;
      r_ser_out     <= 1'b0;
      r_ser_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
    end else if (w_accept) begin
      r_shift       <= MSB_FIRST ? (load_data << 1) : (load_data >> 1);
      r_ser_out     <= MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
      r_par         <= ^load_data;
      r_cnt         <= '0;
      r_ser_valid   <= 1'b1;
      r_frame_start <= 1'b1;
      r_frame_end   <= 1'b0;
    end else if ((r_state != ST_IDLE) && !w_last) begin
      r_cnt         <= w_cnt_inc;
      r_ser_valid   <= 1'b1;
      r_frame_start <= 1'b0;
      r_frame_end   <= (w_cnt_inc == LAST_IDX);
      if (w_next_state == ST_PAR) begin
        r_ser_out <= r_par;
      end else begin
        r_ser_out <= MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
        r_shift   <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
      end
    end else begin
      r_shift       <= '0;
      r_cnt         <= '0;
      r_ser_out     <= 1'b0;
      r_ser_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
    end
  end

  assign ser_out     = r_ser_out;
  assign ser_valid   = r_ser_valid;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances (MSB-first, LSB-first,
// MSB-first with parity) checked bit-by-bit against a shared expected-bit queue.
module tb_piso_serializer;

  typedef struct packed {
    logic [1:0] tag;
    logic       b;
    logic       fs;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] lv = '0;
  logic [7:0] ld = '0;
  logic [2:0] rdy, so, sv, fs, fe, bz;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_msb (
    .clk(clk), .reset(reset), .load_valid(lv[0]), .load_data(ld), .load_ready(rdy[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]), .frame_end(fe[0]), .busy(bz[0]));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .load_valid(lv[1]), .load_data(ld), .load_ready(rdy[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]), .frame_end(fe[1]), .busy(bz[1]));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_par (
    .clk(clk), .reset(reset), .load_valid(lv[2]), .load_data(ld), .load_ready(rdy[2]),
    .ser_out(so[2]), .ser_valid(sv[2]), .frame_start(fs[2]), .frame_end(fe[2]), .busy(bz[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every cycle, each instance is either idle with all outputs low, or
  // presenting exactly the next expected bit of its own frame.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sv[i]) begin
        if (sb.size() == 0) begin
          chk("extra_bit", 32'(sv[i]), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("frame_bit", 32'({2'(i), so[i], fs[i], fe[i]}), 32'(e));
          chk("busy_in_frame", 32'(bz[i]), 32'd1);
          chk("ready_in_frame", 32'(rdy[i]), 32'(e.fe));
        end
      end else begin
        chk("idle_outputs", 32'({bz[i], so[i], fs[i], fe[i]}), 32'd0);
        chk("idle_ready", 32'(rdy[i]), 32'd1);
      end
    end
  end

  task automatic push_frame(input int i, input logic [7:0] d);
    int   len;
    bit   msb;
    exp_t e;
    msb = (i != 1);
    len = (i == 2) ? 9 : 8;
    for (int k = 0; k < len; k++) begin
      e.tag = 2'(i);
      e.b   = (k == 8) ? ^d : (msb ? d[7-k] : d[k]);
      e.fs  = (k == 0);
      e.fe  = (k == len - 1);
      sb.push_back(e);
    end
  endtask

  // Called just after a posedge; returns the cycle stamp of the accepting edge.
  task automatic send(input int i, input logic [7:0] d, input bit hold, output int t);
    int n;
    n = 0;
    lv[i] = 1'b1;
    ld    = d;
    @(negedge clk);
    while (!rdy[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[i]) begin
      chk("load_timeout", 32'(rdy[i]), 32'd1);
      lv[i] = 1'b0;
      t = -1;
    end else begin
      push_frame(i, d);
      @(posedge clk);
      t = cyc;
      #1;
      if (!hold) lv[i] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || bz != 3'b000) && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int t1, t2;

    repeat (3) @(posedge clk);
    #3;
    chk("reset_ready", 32'(rdy), 32'h7);
    chk("reset_outs", 32'({bz, sv, so, fs, fe}), 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // MSB-first A5
    send(0, 8'hA5, 1'b0, t1);
    wait_idle();

    // LSB-first 01
    send(1, 8'h01, 1'b0, t1);
    wait_idle();

    // parity: 07 -> parity 1, 03 -> parity 0
    send(2, 8'h07, 1'b0, t1);
    wait_idle();
    send(2, 8'h03, 1'b0, t1);
    wait_idle();

    // back-to-back FF then 00 with load_valid held
    send(0, 8'hFF, 1'b1, t1);
    send(0, 8'h00, 1'b0, t2);
    chk("b2b_gap", 32'(t2 - t1), 32'd8);
    wait_idle();

    // back-to-back on parity instance: second accept lands on the parity bit
    send(2, 8'h81, 1'b1, t1);
    send(2, 8'h7E, 1'b0, t2);
    chk("b2b_par_gap", 32'(t2 - t1), 32'd9);
    wait_idle();

    // load pulse mid-frame must be ignored
    send(0, 8'hA5, 1'b0, t1);
    repeat (2) @(posedge clk);
    #1;
    lv[0] = 1'b1;
    ld    = 8'h3C;
    chk("busy_rej_ready", 32'(rdy[0]), 32'd0);
    @(posedge clk);
    #1;
    lv[0] = 1'b0;
    wait_idle();
    repeat (12) @(posedge clk);
    #1;

    // asynchronous reset mid-frame, with a load offered during reset
    send(0, 8'hA5, 1'b0, t1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    lv[0] = 1'b1;
    ld    = 8'h5A;
    #1;
    sb.delete();
    chk("midrst_outs", 32'({bz[0], sv[0], so[0], fs[0], fe[0]}), 32'd0);
    chk("midrst_ready", 32'(rdy[0]), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    lv[0] = 1'b0;
    #2;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // frame after reset still correct
    send(1, 8'hC3, 1'b0, t1);
    wait_idle();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
